booth_r4_datapath: RTL and testbench

- Datapath for the radix-4 Booth signed multiplier; sits directly downstream of the multiplier control unit.
- Consumes control strobes c0..c6 and returns the Booth recoding bits (q1, q0, q) and the iteration-end flag (is_count_3).
- Holds multiplicand M, accumulator A, multiplier/low-product Q, extra bit Q[-1] and the iteration counter.
- Drives the 2W-bit signed product on outbus.

---
 rtl/booth_r4_datapath.sv | 78 +++++++
 tb/tb_booth_r4_datapath.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/booth_r4_datapath.sv
// Radix-4 Booth multiplier datapath: operand registers, A/Q/Q[-1] shifter,
// iteration counter and product register, sequenced by the control unit strobes.
module booth_r4_datapath #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic [W-1:0]   inbus,
  input  logic           c0,
  input  logic           c1,
  input  logic           c2,
  input  logic           c3,
  input  logic           c4,
  input  logic           c5,
  input  logic           c6,
  output logic           q1,
  output logic           q0,
  output logic           q,
  output logic           is_count_3,
  output logic [2*W-1:0] outbus
);

  localparam int CW = (W > 2) ? $clog2(W/2) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W/2 - 1);

  logic [W-1:0]   r_m;
  logic [W+1:0]   r_a;
  logic [W-1:0]   r_q;
  logic           r_qm;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_out;

  logic [W+1:0]   w_op;
  logic [W+1:0]   w_sum;

  // Two guard bits on A keep +/-2M in range for every legal recoding step.
  always_comb begin
    w_op  = c3 ? {r_m[W-1], r_m, 1'b0} : {{2{r_m[W-1]}}, r_m};
    w_sum = c4 ? (r_a + ~w_op + (W+2)'(1)) : (r_a + w_op);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_m   <= '0;
      r_a   <= '0;
      r_q   <= '0;
      r_qm  <= 1'b0;
      r_cnt <= '0;
    end else if (c0) begin
      r_m   <= inbus;
      r_a   <= '0;
      r_cnt <= '0;
    end else if (c1) begin
      r_q  <= inbus;
      r_qm <= 1'b0;
    end else if (c2) begin
      r_a <= w_sum;
    end else if (c5) begin
      r_qm  <= r_q[1];
      r_q   <= {r_a[1:0], r_q[W-1:2]};
      r_a   <= {r_a[W+1], r_a[W+1], r_a[W+1:2]};
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Capture sees pre-edge A/Q, so it may share a cycle with any other strobe.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)  r_out <= '0;
    else if (c6) r_out <= {r_a[W-1:0], r_q};
  end

  assign q1         = r_q[1];
  assign q0         = r_q[0];
  assign q          = r_qm;
  assign is_count_3 = (r_cnt == CNT_LAST);
  assign outbus     = r_out;

endmodule

// File: tb/tb_booth_r4_datapath.sv
// Directed bench for booth_r4_datapath: the bench plays the control unit and
// compares products, recoding bits, counter flag and reset behaviour to constants.
module tb_booth_r4_datapath;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [7:0]  inbus = '0;
  logic        c0 = 0, c1 = 0, c2 = 0, c3 = 0, c4 = 0, c5 = 0, c6 = 0;
  logic        q1, q0, q, is_count_3;
  logic [15:0] outbus;

  int total = 0;
  int bad = 0;

  booth_r4_datapath #(.W(8)) dut (
    .clk(clk), .rst_b(rst_b), .inbus(inbus),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6),
    .q1(q1), .q0(q0), .q(q), .is_count_3(is_count_3), .outbus(outbus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // s[i] drives strobe ci for one clock; sampled #1 after the edge.
  task automatic pulse(input logic [6:0] s, input logic [7:0] d);
    {c6, c5, c4, c3, c2, c1, c0} = s;
    inbus = d;
    @(posedge clk);
    #1;
    {c6, c5, c4, c3, c2, c1, c0} = '0;
  endtask

  task automatic booth_step(input logic [2:0] bits);
    case (bits)
      3'b001, 3'b010: pulse(7'b0000100, 8'h00);
      3'b011:         pulse(7'b0001100, 8'h00);
      3'b100:         pulse(7'b0011100, 8'h00);
      3'b101, 3'b110: pulse(7'b0010100, 8'h00);
      default:        pulse(7'b0000000, 8'h00);
    endcase
  endtask

  task automatic run_mult(input string name, input logic [7:0] m, input logic [7:0] qv,
                          input logic [15:0] p, input bit chk_rec, input logic [11:0] rec);
    logic [11:0] seen;
    seen = '0;
    pulse(7'b0000001, m);
    pulse(7'b0000010, qv);
    for (int i = 0; i < 4; i++) begin
      seen = {seen[8:0], q1, q0, q};
      check({name, " is_count_3"}, 32'(is_count_3), 32'(i == 3));
      booth_step({q1, q0, q});
      pulse(7'b0100000, 8'h00);
    end
    if (chk_rec) check({name, " recoding"}, 32'(seen), 32'(rec));
    pulse(7'b1000000, 8'h00);
    check({name, " outbus"}, 32'(outbus), 32'(p));
  endtask

  initial begin
    vecs[0] = '{8'h05, 8'h03, 16'h000F};
    vecs[1] = '{8'h80, 8'h80, 16'h4000};
    vecs[2] = '{8'h7F, 8'h80, 16'hC080};
    vecs[3] = '{8'hF9, 8'h06, 16'hFFD6};
    vecs[4] = '{8'hFF, 8'hFF, 16'h0001};
    vecs[5] = '{8'h7F, 8'h7F, 16'h3F01};
    vecs[6] = '{8'h00, 8'h5A, 16'h0000};
    vecs[7] = '{8'h01, 8'h80, 16'hFF80};
    vecs[8] = '{8'h80, 8'h7F, 16'hC080};
    vecs[9] = '{8'h0C, 8'hF3, 16'hFF64};

    // Reset held low while every strobe toggles.
    rst_b = 1'b0;
    #2;
    pulse(7'b1111111, 8'hA5);
    pulse(7'b1111111, 8'h5A);
    check("rst q1q0q", 32'({q1, q0, q}), 32'h0);
    check("rst is_count_3", 32'(is_count_3), 32'h0);
    check("rst outbus", 32'(outbus), 32'h0);

    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    // M=0x7F, A cleared; +M then capture shows {A[7:0], Q}.
    pulse(7'b0000001, 8'h7F);
    check("load cnt0", 32'(is_count_3), 32'h0);
    pulse(7'b0000100, 8'h00);
    pulse(7'b1000000, 8'h00);
    check("load M via +M", 32'(outbus), 32'h7F00);

    // Counter: flag seen during each of four shifts, then wrap.
    pulse(7'b0000001, 8'h00);
    for (int i = 0; i < 4; i++) begin
      check("cnt flag", 32'(is_count_3), 32'(i == 3));
      pulse(7'b0100000, 8'h00);
    end
    check("cnt wrap", 32'(is_count_3), 32'h0);
    pulse(7'b0100000, 8'h00);
    check("cnt after 5th", 32'(is_count_3), 32'h0);

    // Radix-4 digits of 3 are -1, +1: recoding 110 then 001.
    run_mult("mul 5x3", 8'h05, 8'h03, 16'h000F, 1'b1, {3'b110, 3'b001, 3'b000, 3'b000});
    for (int i = 1; i < 10; i++)
      run_mult($sformatf("mul vec%0d", i), vecs[i].m, vecs[i].q, vecs[i].p, 1'b0, 12'h0);

    // Priority: c0 wins over c1 when both are asserted.
    pulse(7'b0000010, 8'h00);
    pulse(7'b0000011, 8'h33);
    pulse(7'b0000100, 8'h00);
    pulse(7'b1000000, 8'h00);
    check("prio c0>c1", 32'(outbus), 32'h3300);

    // Abort mid-multiplication with an asynchronous reset after the 2nd shift.
    pulse(7'b1000000, 8'h00);
    pulse(7'b0000001, 8'h05);
    pulse(7'b0000010, 8'h03);
    pulse(7'b0010100, 8'h00);
    pulse(7'b0100000, 8'h00);
    pulse(7'b0000100, 8'h00);
    pulse(7'b0100000, 8'h00);
    check("pre-abort outbus", 32'(outbus), 32'h3300);
    #2;
    rst_b = 1'b0;
    #1;
    check("abort outbus", 32'(outbus), 32'h0);
    check("abort q1q0q", 32'({q1, q0, q}), 32'h0);
    check("abort is_count_3", 32'(is_count_3), 32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    run_mult("mul 2x3", 8'h02, 8'h03, 16'h0006, 1'b0, 12'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
